// File: rtl/ctrl_pipe_skid_if.sv
// Valid/ready handshake bundle carrying one WIDTH-bit control word.
// The master drives valid/data, the slave drives ready.
interface ctrl_pipe_skid_if #(
    parameter int WIDTH = 13
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ctrl_pipe_skid.sv
// Control-word pipeline stage with valid/ready handshake, flush-to-bubble and an
// optional 2-entry skid buffer. Empty entries always hold CLEAR_VAL.
module ctrl_pipe_skid #(
    parameter int               WIDTH     = 13,
    parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}},
    parameter bit               SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    ctrl_pipe_skid_if.slave   up,
    ctrl_pipe_skid_if.master  dn,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r, state_nx;
    logic [WIDTH-1:0] main_r, main_nx;
    logic [WIDTH-1:0] skid_r, skid_nx;
    logic             valid_r;
    logic             ready_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             deliver_s;

    // Handshake events; the skid variant takes in_ready straight from a flop.
    always_comb begin
        in_ready_s = SKID ? ready_r : (~valid_r | dn.ready);
        accept_s   = up.valid & in_ready_s;
        deliver_s  = valid_r & dn.ready;
    end

    // Next-state and next-data: flush wins over any handshake in the same cycle.
    always_comb begin
        state_nx = state_r;
        main_nx  = main_r;
        skid_nx  = skid_r;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = CLEAR_VAL;
            skid_nx  = CLEAR_VAL;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_nx  = up.data;
                        state_nx = ONE;
                    end else begin
                        main_nx  = CLEAR_VAL;
                    end
                end
                ONE: begin
                    if (accept_s && deliver_s) begin
                        main_nx  = up.data;
                    end else if (accept_s) begin
                        skid_nx  = up.data;
                        state_nx = FULL;
                    end else if (deliver_s) begin
                        main_nx  = CLEAR_VAL;
                        state_nx = EMPTY;
                    end else begin
                        state_nx = ONE;
                    end
                end
                FULL: begin
                    if (deliver_s) begin
                        main_nx  = skid_r;
                        skid_nx  = CLEAR_VAL;
                        state_nx = ONE;
                    end else begin
                        state_nx = FULL;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = CLEAR_VAL;
                    skid_nx  = CLEAR_VAL;
                end
            endcase
        end
    end

    // State/data registers with synchronous reset; valid and ready are registered copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            main_r  <= CLEAR_VAL;
            skid_r  <= CLEAR_VAL;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nx;
            main_r  <= main_nx;
            skid_r  <= skid_nx;
            valid_r <= (state_nx != EMPTY);
            ready_r <= (state_nx != FULL);
        end
    end

    assign up.ready  = in_ready_s;
    assign dn.valid  = valid_r;
    assign dn.data   = main_r;
    assign occupancy = state_r;

endmodule
